data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Target-side data memory for the CPU's memory-access port. It decodes the CPU's read/write control, 16-bit byte address and 32-bit write-data bus, and holds a word-organised RAM. It returns read data combinationally on the CPU's data-in bus. It models a configurable access latency by driving the CPU's pipeline HALT input for a fixed number of cycles per new access, and flags out-of-range addresses.

## Interface
- DEPTH, 1024: RAM size in 32-bit words; legal range 1..16384.
- WAIT_STATES, 0: HALT cycles inserted per new access; legal range 0..15.
- CK_REF  in  1  clock; all state updates on the rising edge.
- int_rst_n  in  1  reset, asynchronous, active-low.
- MEM_ACCESS_READ_WRN  in  1  1 = read, 0 = write.
- MEM_ACCESS_ADDRESS_BUS  in  16  byte address.
- MEM_ACCESS_DATA_OUT_BUS  in  32  write data from the CPU.
- MEM_ACCESS_DATA_IN_BUS  out  32  read data to the CPU.
- HALT  out  1  pipeline stall request to the CPU.
- MEM_ERR  out  1  one-cycle pulse on a completed out-of-range access.

## Operation
- Word index is addr[15:2]. addr[1:0] is ignored; all accesses are whole-word.
  - The CPU has already sign/zero-adjusted halfword and byte store data to 32 bits.
- In range: word index < DEPTH.
- Read path is asynchronous: DATA_IN_BUS = mem[index] when in range, else 32'h0. It is valid every cycle in every state.
- A write is committed on the completion edge (defined below) when in range. An out-of-range write is dropped.
- New access, evaluated only in IDLE:
  - READ_WRN=0; or
  - READ_WRN=1 and (last_valid=0 or addr != last_addr or last access was a write).
- On completion: last_addr <= addr, last_valid <= 1, last_was_write <= !READ_WRN.
- Back-to-back writes are always new accesses. Repeated reads of the same address are not: no stall, no MEM_ERR.
- FSM states: IDLE, WAIT, DONE.
  - WAIT_STATES=0: FSM stays in IDLE. Every new access completes at the edge ending the cycle in which it is detected. HALT stays 0.
  - IDLE, new access, WAIT_STATES=1: HALT=1 combinationally. Completion at that edge; go to DONE.
  - IDLE, new access, WAIT_STATES>=2: HALT=1 combinationally. At the edge, cnt <= WAIT_STATES-1; go to WAIT.
  - WAIT: HALT=1. If cnt==1, completion at this edge and go to DONE; else cnt <= cnt-1.
  - DONE: HALT=0 and no access detection. The CPU advances at the end of this cycle; go to IDLE.
- MEM_ERR is registered: it is 1 for the one cycle after a completion edge whose address was out of range, else 0.
- Memory array contents are not reset.

## Timing
- Reset values:
  - HALT=0, MEM_ERR=0, state=IDLE, cnt=0.
  - last_valid=0, last_was_write=0, last_addr=0.
  - DATA_IN_BUS follows the array combinationally and has no reset value.
- HALT is high for exactly WAIT_STATES consecutive cycles per new access. It is followed by one DONE cycle (HALT=0) when WAIT_STATES>0.
- The CPU holds the bus stable while HALT=1; the responder relies on this.
- Read data seen by the CPU at the DONE-cycle edge is mem[index] including any write committed earlier.
- Same-edge read-after-write to one address: a read of the address being written returns the old word until the commit edge.
- Reset asserted mid-access (WAIT or DONE):
  - HALT drops immediately (asynchronous).
  - A pending write is not committed.
  - state=IDLE and last_valid=0.
  - After release, the still-present bus access is detected as new.
- cnt never wraps. WAIT_STATES=15 gives 15 HALT cycles.

## Test plan
- WAIT_STATES=0: write 0xDEADBEEF to addr 0x0010, then read 0x0010 -> DATA_IN=0xDEADBEEF the next cycle; HALT never 1.
- WAIT_STATES=3: write 0x12345678 to 0x0004 -> HALT=1 for 3 cycles, then 1 DONE cycle with HALT=0; mem[1] still old during HALT, =0x12345678 after the completion edge.
- WAIT_STATES=2: read 0x0008 three consecutive times after one stall -> HALT pulses for 2 cycles only on the first read; 0x0008→0x000C address change causes a fresh 2-cycle HALT.
- DEPTH=1024: write to 0x1000 -> array unchanged, DATA_IN=0, MEM_ERR=1 for exactly 1 cycle after completion; repeated reads of 0x1000 give no further pulse.
- WAIT_STATES=4: assert int_rst_n low during the 2nd HALT cycle of a write of 0xA5A5A5A5 to 0x0020 -> HALT falls asynchronously and mem[8] is unchanged; after release, the held write is re-detected and commits after 4 HALT cycles.
- addr 0x0013 and 0x0010 alias the same word: write 0x0000FFFF via 0x0013, read via 0x0010 -> 0x0000FFFF.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// CPU memory-access port bundle: read/write control, byte address, write data,
// plus the responder's read data, HALT stall request and MEM_ERR pulse.
interface data_mem_responder_if;
  logic        MEM_ACCESS_READ_WRN;
  logic [15:0] MEM_ACCESS_ADDRESS_BUS;
  logic [31:0] MEM_ACCESS_DATA_OUT_BUS;
  logic [31:0] MEM_ACCESS_DATA_IN_BUS;
  logic        HALT;
  logic        MEM_ERR;

  modport master (
    output MEM_ACCESS_READ_WRN,
    output MEM_ACCESS_ADDRESS_BUS,
    output MEM_ACCESS_DATA_OUT_BUS,
    input  MEM_ACCESS_DATA_IN_BUS,
    input  HALT,
    input  MEM_ERR
  );

  modport slave (
    input  MEM_ACCESS_READ_WRN,
    input  MEM_ACCESS_ADDRESS_BUS,
    input  MEM_ACCESS_DATA_OUT_BUS,
    output MEM_ACCESS_DATA_IN_BUS,
    output HALT,
    output MEM_ERR
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM on the CPU memory-access port with a fixed per-access
// HALT latency, asynchronous read path and a registered out-of-range error pulse.
module data_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic                 CK_REF,
  input logic                 int_rst_n,
  data_mem_responder_if.slave bus
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [14:0] DEPTH_W  = 15'(DEPTH);
  localparam logic [3:0]  CNT_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [31:0] mem [DEPTH];
  logic [13:0] word_idx;
  logic [AW-1:0] mem_idx;
  logic        in_range;
  logic        last_valid, last_was_write;
  logic [15:0] last_addr;
  logic        new_access, halt_c, complete, commit, mem_err;

  assign word_idx = bus.MEM_ACCESS_ADDRESS_BUS[15:2];
  assign mem_idx  = word_idx[AW-1:0];
  assign in_range = ({1'b0, word_idx} < DEPTH_W);

  assign bus.MEM_ACCESS_DATA_IN_BUS = in_range ? mem[mem_idx] : 32'h0;

  // Repeated reads of the last-completed address are served without a stall.
  assign new_access = !bus.MEM_ACCESS_READ_WRN || !last_valid || last_was_write ||
                      (bus.MEM_ACCESS_ADDRESS_BUS != last_addr);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    halt_c     = 1'b0;
    complete   = 1'b0;
    unique case (state)
      IDLE: begin
        if (new_access) begin
          if (WAIT_STATES == 0) begin
            complete = 1'b1;
          end else if (WAIT_STATES == 1) begin
            halt_c     = 1'b1;
            complete   = 1'b1;
            state_next = DONE;
          end else begin
            halt_c     = 1'b1;
            cnt_next   = CNT_LOAD;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        halt_c   = 1'b1;
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          complete   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reset must silence HALT and suppress any commit even while the bus is busy.
  assign bus.HALT = halt_c & int_rst_n;
  assign commit   = complete & int_rst_n;
  assign bus.MEM_ERR = mem_err;

  always_ff @(posedge CK_REF or negedge int_rst_n) begin
    if (!int_rst_n) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      mem_err        <= 1'b0;
      last_valid     <= 1'b0;
      last_was_write <= 1'b0;
      last_addr      <= 16'h0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      mem_err <= commit && !in_range;
      if (commit) begin
        last_valid     <= 1'b1;
        last_was_write <= !bus.MEM_ACCESS_READ_WRN;
        last_addr      <= bus.MEM_ACCESS_ADDRESS_BUS;
      end
    end
  end

  always_ff @(posedge CK_REF) begin
    if (commit && !bus.MEM_ACCESS_READ_WRN && in_range)
      mem[mem_idx] <= bus.MEM_ACCESS_DATA_OUT_BUS;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: four instances with WAIT_STATES 0/2/3/4
// exercise latency, repeated-read suppression, out-of-range and mid-access reset.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst_n;
  logic rst_n4;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  always #5 clk = ~clk;

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus2 ();
  data_mem_responder_if bus3 ();
  data_mem_responder_if bus4 ();

  data_mem_responder #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (.CK_REF(clk), .int_rst_n(rst_n),  .bus(bus0));
  data_mem_responder #(.DEPTH(1024), .WAIT_STATES(2)) dut2 (.CK_REF(clk), .int_rst_n(rst_n),  .bus(bus2));
  data_mem_responder #(.DEPTH(1024), .WAIT_STATES(3)) dut3 (.CK_REF(clk), .int_rst_n(rst_n),  .bus(bus3));
  data_mem_responder #(.DEPTH(1024), .WAIT_STATES(4)) dut4 (.CK_REF(clk), .int_rst_n(rst_n4), .bus(bus4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] halts, errs;
    @(negedge clk);
    halts = {bus0.HALT, bus2.HALT, bus3.HALT, bus4.HALT};
    errs  = {bus0.MEM_ERR, bus2.MEM_ERR, bus3.MEM_ERR, bus4.MEM_ERR};
    n_compared++;
    if (halts !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_halt: observed %b expected %b", halts, 4'b0000);
    end
    n_compared++;
    if (errs !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_mem_err: observed %b expected %b", errs, 4'b0000);
    end
  endtask

  task automatic test_ws0_write_read();
    tick();
    bus0.MEM_ACCESS_READ_WRN     = 1'b0;
    bus0.MEM_ACCESS_ADDRESS_BUS  = 16'h0010;
    bus0.MEM_ACCESS_DATA_OUT_BUS = 32'hDEADBEEF;
    @(negedge clk);
    n_compared++;
    if (bus0.HALT !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL ws0_write_halt: observed %b expected 0", bus0.HALT);
    end
    tick();
    bus0.MEM_ACCESS_READ_WRN = 1'b1;
    @(negedge clk);
    n_compared++;
    if (bus0.MEM_ACCESS_DATA_IN_BUS !== 32'hDEADBEEF) begin
      n_mismatched++;
      $display("[TB] FAIL ws0_read_data: observed %h expected %h", bus0.MEM_ACCESS_DATA_IN_BUS, 32'hDEADBEEF);
    end
    n_compared++;
    if (bus0.HALT !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL ws0_read_halt: observed %b expected 0", bus0.HALT);
    end
  endtask

  task automatic test_alias();
    tick();
    bus0.MEM_ACCESS_READ_WRN     = 1'b0;
    bus0.MEM_ACCESS_ADDRESS_BUS  = 16'h0013;
    bus0.MEM_ACCESS_DATA_OUT_BUS = 32'h0000FFFF;
    @(negedge clk);
    n_compared++;
    if (bus0.MEM_ACCESS_DATA_IN_BUS !== 32'hDEADBEEF) begin
      n_mismatched++;
      $display("[TB] FAIL alias_old_word: observed %h expected %h", bus0.MEM_ACCESS_DATA_IN_BUS, 32'hDEADBEEF);
    end
    tick();
    bus0.MEM_ACCESS_READ_WRN    = 1'b1;
    bus0.MEM_ACCESS_ADDRESS_BUS = 16'h0010;
    @(negedge clk);
    n_compared++;
    if (bus0.MEM_ACCESS_DATA_IN_BUS !== 32'h0000FFFF) begin
      n_mismatched++;
      $display("[TB] FAIL alias_read: observed %h expected %h", bus0.MEM_ACCESS_DATA_IN_BUS, 32'h0000FFFF);
    end
  endtask

  task automatic test_ws3_write_latency();
    logic        exp_h;
    logic [31:0] exp_d;
    tick();
    bus3.MEM_ACCESS_READ_WRN     = 1'b0;
    bus3.MEM_ACCESS_ADDRESS_BUS  = 16'h0004;
    bus3.MEM_ACCESS_DATA_OUT_BUS = 32'h0BADF00D;
    repeat (4) tick();
    bus3.MEM_ACCESS_DATA_OUT_BUS = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_h = (i < 3);
      exp_d = (i < 3) ? 32'h0BADF00D : 32'h12345678;
      n_compared++;
      if (bus3.HALT !== exp_h) begin
        n_mismatched++;
        $display("[TB] FAIL ws3_halt[%0d]: observed %b expected %b", i, bus3.HALT, exp_h);
      end
      n_compared++;
      if (bus3.MEM_ACCESS_DATA_IN_BUS !== exp_d) begin
        n_mismatched++;
        $display("[TB] FAIL ws3_data[%0d]: observed %h expected %h", i, bus3.MEM_ACCESS_DATA_IN_BUS, exp_d);
      end
      tick();
    end
    bus3.MEM_ACCESS_READ_WRN = 1'b1;
  endtask

  task automatic test_ws2_repeat_reads();
    logic [4:0] exp_h;
    tick();
    bus2.MEM_ACCESS_READ_WRN    = 1'b1;
    bus2.MEM_ACCESS_ADDRESS_BUS = 16'h0008;
    exp_h = 5'b11000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_compared++;
      if (bus2.HALT !== exp_h[4-i]) begin
        n_mismatched++;
        $display("[TB] FAIL ws2_repeat_halt[%0d]: observed %b expected %b", i, bus2.HALT, exp_h[4-i]);
      end
      n_compared++;
      if (bus2.MEM_ERR !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL ws2_repeat_err[%0d]: observed %b expected 0", i, bus2.MEM_ERR);
      end
      tick();
    end
    bus2.MEM_ACCESS_ADDRESS_BUS = 16'h000C;
    exp_h = 5'b11000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_compared++;
      if (bus2.HALT !== exp_h[4-i]) begin
        n_mismatched++;
        $display("[TB] FAIL ws2_newaddr_halt[%0d]: observed %b expected %b", i, bus2.HALT, exp_h[4-i]);
      end
      tick();
    end
  endtask

  task automatic test_out_of_range();
    logic [4:0] exp_h, exp_e;
    bus2.MEM_ACCESS_READ_WRN     = 1'b0;
    bus2.MEM_ACCESS_ADDRESS_BUS  = 16'h0000;
    bus2.MEM_ACCESS_DATA_OUT_BUS = 32'hCAFEF00D;
    repeat (3) tick();
    bus2.MEM_ACCESS_ADDRESS_BUS  = 16'h1000;
    bus2.MEM_ACCESS_DATA_OUT_BUS = 32'h55555555;
    exp_h = 5'b11000;
    exp_e = 5'b00100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_compared++;
      if (bus2.HALT !== exp_h[4-i]) begin
        n_mismatched++;
        $display("[TB] FAIL oor_write_halt[%0d]: observed %b expected %b", i, bus2.HALT, exp_h[4-i]);
      end
      n_compared++;
      if (bus2.MEM_ERR !== exp_e[4-i]) begin
        n_mismatched++;
        $display("[TB] FAIL oor_write_err[%0d]: observed %b expected %b", i, bus2.MEM_ERR, exp_e[4-i]);
      end
      n_compared++;
      if (bus2.MEM_ACCESS_DATA_IN_BUS !== 32'h0) begin
        n_mismatched++;
        $display("[TB] FAIL oor_write_data[%0d]: observed %h expected 0", i, bus2.MEM_ACCESS_DATA_IN_BUS);
      end
      tick();
    end
    bus2.MEM_ACCESS_READ_WRN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_compared++;
      if (bus2.HALT !== exp_h[4-i]) begin
        n_mismatched++;
        $display("[TB] FAIL oor_read_halt[%0d]: observed %b expected %b", i, bus2.HALT, exp_h[4-i]);
      end
      n_compared++;
      if (bus2.MEM_ERR !== exp_e[4-i]) begin
        n_mismatched++;
        $display("[TB] FAIL oor_read_err[%0d]: observed %b expected %b", i, bus2.MEM_ERR, exp_e[4-i]);
      end
      n_compared++;
      if (bus2.MEM_ACCESS_DATA_IN_BUS !== 32'h0) begin
        n_mismatched++;
        $display("[TB] FAIL oor_read_data[%0d]: observed %h expected 0", i, bus2.MEM_ACCESS_DATA_IN_BUS);
      end
      tick();
    end
    bus2.MEM_ACCESS_ADDRESS_BUS = 16'h0000;
    @(negedge clk);
    n_compared++;
    if (bus2.MEM_ACCESS_DATA_IN_BUS !== 32'hCAFEF00D) begin
      n_mismatched++;
      $display("[TB] FAIL oor_array_intact: observed %h expected %h", bus2.MEM_ACCESS_DATA_IN_BUS, 32'hCAFEF00D);
    end
  endtask

  task automatic test_reset_mid_access();
    logic        exp_h;
    logic [31:0] exp_d;
    tick();
    bus4.MEM_ACCESS_READ_WRN     = 1'b0;
    bus4.MEM_ACCESS_ADDRESS_BUS  = 16'h0020;
    bus4.MEM_ACCESS_DATA_OUT_BUS = 32'h11111111;
    repeat (5) tick();
    bus4.MEM_ACCESS_DATA_OUT_BUS = 32'hA5A5A5A5;
    tick();
    @(negedge clk);
    n_compared++;
    if (bus4.HALT !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL rst_mid_halt_before: observed %b expected 1", bus4.HALT);
    end
    #1 rst_n4 = 1'b0;
    #1;
    n_compared++;
    if (bus4.HALT !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL rst_mid_halt_async: observed %b expected 0", bus4.HALT);
    end
    tick();
    n_compared++;
    if (bus4.MEM_ACCESS_DATA_IN_BUS !== 32'h11111111) begin
      n_mismatched++;
      $display("[TB] FAIL rst_mid_no_commit: observed %h expected %h", bus4.MEM_ACCESS_DATA_IN_BUS, 32'h11111111);
    end
    rst_n4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_h = (i < 4);
      exp_d = (i < 4) ? 32'h11111111 : 32'hA5A5A5A5;
      n_compared++;
      if (bus4.HALT !== exp_h) begin
        n_mismatched++;
        $display("[TB] FAIL rst_redetect_halt[%0d]: observed %b expected %b", i, bus4.HALT, exp_h);
      end
      n_compared++;
      if (bus4.MEM_ACCESS_DATA_IN_BUS !== exp_d) begin
        n_mismatched++;
        $display("[TB] FAIL rst_redetect_data[%0d]: observed %h expected %h", i, bus4.MEM_ACCESS_DATA_IN_BUS, exp_d);
      end
      tick();
    end
    bus4.MEM_ACCESS_READ_WRN = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    rst_n4 = 1'b0;
    bus0.MEM_ACCESS_READ_WRN = 1'b1; bus0.MEM_ACCESS_ADDRESS_BUS = 16'h0; bus0.MEM_ACCESS_DATA_OUT_BUS = 32'h0;
    bus2.MEM_ACCESS_READ_WRN = 1'b1; bus2.MEM_ACCESS_ADDRESS_BUS = 16'h0; bus2.MEM_ACCESS_DATA_OUT_BUS = 32'h0;
    bus3.MEM_ACCESS_READ_WRN = 1'b1; bus3.MEM_ACCESS_ADDRESS_BUS = 16'h0; bus3.MEM_ACCESS_DATA_OUT_BUS = 32'h0;
    bus4.MEM_ACCESS_READ_WRN = 1'b1; bus4.MEM_ACCESS_ADDRESS_BUS = 16'h0; bus4.MEM_ACCESS_DATA_OUT_BUS = 32'h0;
    repeat (2) tick();
    test_reset();
    tick();
    rst_n  = 1'b1;
    rst_n4 = 1'b1;
    repeat (8) tick();
    test_ws0_write_read();
    test_alias();
    test_ws3_write_latency();
    test_ws2_repeat_reads();
    test_out_of_range();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
